// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction memory port, execute redirect, and decode handshake.
interface instruction_fetch_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned XLEN       = 32
);
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_data;
    logic                  redirect_valid;
    logic [XLEN-1:0]       redirect_pc;
    logic                  id_valid;
    logic                  id_ready;
    logic [DATA_WIDTH-1:0] id_instr;
    logic [XLEN-1:0]       id_pc;
    logic                  id_fault;
    logic                  redirect_misaligned;

    // Fetch unit side
    modport master (
        output imem_addr, id_valid, id_instr, id_pc, id_fault, redirect_misaligned,
        input  imem_data, redirect_valid, redirect_pc, id_ready
    );

    // Memory / execute / decode side
    modport slave (
        input  imem_addr, id_valid, id_instr, id_pc, id_fault, redirect_misaligned,
        output imem_data, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/instruction_fetch.sv
// PC generator and fetch front end: hides the 1-cycle instruction memory latency,
// absorbs decode back-pressure in a 1-entry buffer, and applies execute redirects.
module instruction_fetch #(
    parameter int unsigned   ADDR_WIDTH = 12,
    parameter int unsigned   DATA_WIDTH = 32,
    parameter int unsigned   XLEN       = 32,
    parameter bit [XLEN-1:0] RESET_PC   = '0
) (
    input logic                 clk,
    input logic                 reset_n,
    instruction_fetch_if.master bus
);
    logic [XLEN-1:0]       pc_q, pc_d;
    logic                  infl_valid_q, infl_valid_d;
    logic [XLEN-1:0]       infl_pc_q, infl_pc_d;
    logic                  hold_valid_q, hold_valid_d;
    logic [DATA_WIDTH-1:0] hold_instr_q, hold_instr_d;
    logic [XLEN-1:0]       hold_pc_q, hold_pc_d;
    logic                  misaligned_q, misaligned_d;

    logic                  id_valid_c;
    logic                  stall_c;
    logic [XLEN-1:0]       offer_pc_c;
    logic [DATA_WIDTH-1:0] offer_instr_c;

    // Offer source: stall buffer first, then the in-flight memory response.
    // A same-cycle redirect kills the offer since it is younger than the branch.
    assign id_valid_c    = reset_n && !bus.redirect_valid && (hold_valid_q || infl_valid_q);
    assign offer_pc_c    = hold_valid_q ? hold_pc_q    : infl_pc_q;
    assign offer_instr_c = hold_valid_q ? hold_instr_q : bus.imem_data;
    assign stall_c       = id_valid_c && !bus.id_ready;

    assign bus.imem_addr           = pc_q[ADDR_WIDTH+1:2];
    assign bus.id_valid            = id_valid_c;
    assign bus.id_instr            = id_valid_c ? offer_instr_c : '0;
    assign bus.id_pc               = id_valid_c ? offer_pc_c : '0;
    assign bus.id_fault            = id_valid_c && ((offer_pc_c >> (ADDR_WIDTH + 2)) != '0);
    assign bus.redirect_misaligned = misaligned_q && reset_n;

    // Next-state: redirect beats stall; a stalled infl response moves into hold and
    // its successor request is squashed so the same address is re-issued.
    always_comb begin
        pc_d         = pc_q;
        infl_valid_d = 1'b0;
        infl_pc_d    = infl_pc_q;
        hold_valid_d = hold_valid_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        misaligned_d = 1'b0;
        if (bus.redirect_valid) begin
            pc_d         = {bus.redirect_pc[XLEN-1:2], 2'b00};
            hold_valid_d = 1'b0;
            misaligned_d = |bus.redirect_pc[1:0];
        end else if (stall_c && !hold_valid_q) begin
            hold_valid_d = 1'b1;
            hold_instr_d = bus.imem_data;
            hold_pc_d    = infl_pc_q;
        end else if (stall_c) begin
            hold_valid_d = 1'b1;
        end else begin
            hold_valid_d = 1'b0;
            infl_valid_d = 1'b1;
            infl_pc_d    = pc_q;
            pc_d         = pc_q + XLEN'(4);
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q         <= RESET_PC;
            infl_valid_q <= 1'b0;
            infl_pc_q    <= '0;
            hold_valid_q <= 1'b0;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
            misaligned_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            infl_valid_q <= infl_valid_d;
            infl_pc_q    <= infl_pc_d;
            hold_valid_q <= hold_valid_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            misaligned_q <= misaligned_d;
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: program-order stream model plus directed literal checks.
module tb_instruction_fetch;
    localparam int unsigned ADDR_WIDTH = 12;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned XLEN       = 32;
    localparam logic [31:0] RESET_PC   = 32'h0;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    instruction_fetch_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .XLEN(XLEN)) bus ();

    instruction_fetch #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .XLEN(XLEN), .RESET_PC(RESET_PC)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory: word i holds 0xA000_0000 + i, one cycle read latency
    always @(posedge clk) bus.imem_data <= 32'hA000_0000 + 32'(bus.imem_addr);

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return 32'hA000_0000 + ((pc >> 2) & 32'hFFF);
    endfunction

    // Stream model: the next program-order PC to offer plus a count of empty cycles
    // still owed after reset or a redirect.
    logic [31:0] m_pc;
    int          m_wait;
    logic        m_mis;
    bit          m_live = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                check("rst_valid", 64'(bus.id_valid), 64'd0);
                check("rst_mis", 64'(bus.redirect_misaligned), 64'd0);
                m_pc   = RESET_PC;
                m_wait = 1;
                m_mis  = 1'b0;
                m_live = 1'b1;
            end else if (m_live) begin
                check("m_mis", 64'(bus.redirect_misaligned), 64'(m_mis));
                m_mis = 1'b0;
                if (bus.redirect_valid || m_wait > 0) begin
                    check("m_valid0", 64'(bus.id_valid), 64'd0);
                    check("m_pc0", 64'(bus.id_pc), 64'd0);
                    check("m_instr0", 64'(bus.id_instr), 64'd0);
                    check("m_fault0", 64'(bus.id_fault), 64'd0);
                    if (bus.redirect_valid) begin
                        m_pc   = {bus.redirect_pc[31:2], 2'b00};
                        m_wait = 1;
                        m_mis  = |bus.redirect_pc[1:0];
                    end else begin
                        m_wait--;
                    end
                end else begin
                    check("m_valid", 64'(bus.id_valid), 64'd1);
                    check("m_pc", 64'(bus.id_pc), 64'(m_pc));
                    check("m_instr", 64'(bus.id_instr), 64'(mem_word(m_pc)));
                    check("m_fault", 64'(bus.id_fault), 64'(m_pc >= 32'h4000));
                    check("m_addr", 64'(bus.imem_addr), 64'(((m_pc + 32'd4) >> 2) & 32'hFFF));
                    if (bus.id_ready) m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    // One cycle of stimulus; returns just after the negedge so literal checks see that cycle
    task automatic drive(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
        @(posedge clk);
        #1;
        reset_n            = rst;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.id_ready       = rdy;
        @(negedge clk);
        #1;
    endtask

    task automatic expect_offer(input string name, input logic [31:0] pc, input logic [31:0] instr);
        check({name, "_valid"}, 64'(bus.id_valid), 64'd1);
        check({name, "_pc"}, 64'(bus.id_pc), 64'(pc));
        check({name, "_instr"}, 64'(bus.id_instr), 64'(instr));
    endtask

    logic [31:0] pattern;

    initial begin
        reset_n            = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.id_ready       = 1'b1;

        // Reset, then straight-line fetch with no bubbles
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        check("reset_valid", 64'(bus.id_valid), 64'd0);
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        check("first_cycle_valid", 64'(bus.id_valid), 64'd0);
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        expect_offer("seq0", 32'h0, 32'hA000_0000);
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        expect_offer("seq1", 32'h4, 32'hA000_0001);

        // Three-cycle stall on 0x8, release, then 0xC without a bubble
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b0);
            expect_offer("stall", 32'h8, 32'hA000_0002);
        end
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        expect_offer("release", 32'h8, 32'hA000_0002);
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        expect_offer("after_release", 32'hC, 32'hA000_0003);

        // Redirect to 0x40 in the cycle 0x10 would be offered
        drive(1'b1, 1'b1, 32'h40, 1'b1);
        check("redir_same_valid", 64'(bus.id_valid), 64'd0);
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        check("redir_next_valid", 64'(bus.id_valid), 64'd0);
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        expect_offer("redir_tgt", 32'h40, 32'hA000_0010);
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        expect_offer("redir_tgt1", 32'h44, 32'hA000_0011);

        // Redirect while the stall buffer holds 0x48
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        expect_offer("held", 32'h48, 32'hA000_0012);
        drive(1'b1, 1'b1, 32'h80, 1'b1);
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        expect_offer("redir_stall", 32'h80, 32'hA000_0020);

        // Misaligned redirect target
        drive(1'b1, 1'b1, 32'h42, 1'b1);
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        check("mis_pulse", 64'(bus.redirect_misaligned), 64'd1);
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        check("mis_clear", 64'(bus.redirect_misaligned), 64'd0);
        expect_offer("mis_tgt", 32'h40, 32'hA000_0010);

        // Top of memory range and aliasing beyond it
        drive(1'b1, 1'b1, 32'h3FFC, 1'b1);
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        expect_offer("top", 32'h3FFC, 32'hA000_0FFF);
        check("top_fault", 64'(bus.id_fault), 64'd0);
        check("top_addr", 64'(bus.imem_addr), 64'd0);
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        expect_offer("alias", 32'h4000, 32'hA000_0000);
        check("alias_fault", 64'(bus.id_fault), 64'd1);
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        drive(1'b1, 1'b0, 32'h0, 1'b0);

        // Reset in the middle of a stall
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        check("midrst_valid", 64'(bus.id_valid), 64'd0);
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        check("midrst_next_valid", 64'(bus.id_valid), 64'd0);
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        expect_offer("restart", RESET_PC, 32'hA000_0000);

        // PC wrap at 2^32
        drive(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        expect_offer("wrap_top", 32'hFFFF_FFFC, 32'hA000_0FFF);
        check("wrap_top_fault", 64'(bus.id_fault), 64'd1);
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        expect_offer("wrap_zero", 32'h0, 32'hA000_0000);
        check("wrap_zero_fault", 64'(bus.id_fault), 64'd0);

        // Irregular back-pressure pattern, checked by the stream model
        pattern = 32'b1011_0011_1000_1101_0110_0001_1110_0101;
        for (int i = 0; i < 32; i++) drive(1'b1, 1'b0, 32'h0, pattern[i]);
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        drive(1'b1, 1'b0, 32'h0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
